bidir_serial_tx: RTL and testbench

//  Parallel-in, serial-out transmitter that feeds the bidirectional shift register receiver.

---
 rtl/bidir_serial_tx.sv | 120 ++++++++++++
 tb/tb_bidir_serial_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bidir_serial_tx.sv
// Parallel-in, serial-out transmitter feeding a bidirectional shift-register receiver.
// Optional even-parity trailer bit is built only when PARITY_EN is defined.
module bidir_serial_tx #(
   parameter int N = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_valid_i,
   output logic         load_ready_o,
   input  logic [N-1:0] load_data_i,
   input  logic         load_mode_i,
   output logic         sdata_o,
   output logic         sen_o,
   output logic         busy_o,
   output logic         done_o
);

   // state | meaning
   // IDLE  | no frame in progress, outputs quiet, ready for a word
   // SHIFT | one frame bit per cycle on sdata with sen=1

   localparam int CW = $clog2(N + 1);
`ifdef PARITY_EN
   localparam int LAST = N;
`else
   localparam int LAST = N - 1;
`endif
   localparam logic [CW-1:0] LAST_C = CW'(LAST);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t        state_q;
   logic [N-1:0]  shreg_q;
   logic          mode_q;
   logic [CW-1:0] cnt_q;
   logic          sdata_q;
   logic          sen_q;
   logic          busy_q;
   logic          done_q;
`ifdef PARITY_EN
   logic          parity_q;
`endif

   logic          last_c;
   logic          xfer_c;
   logic [CW-1:0] cnt_inc_c;

   assign last_c       = (state_q == SHIFT) && (cnt_q == LAST_C);
   assign load_ready_o = (state_q == IDLE) || last_c;
   assign xfer_c       = load_valid_i && load_ready_o;
   assign cnt_inc_c    = cnt_q + CW'(1);

   assign sdata_o = sdata_q;
   assign sen_o   = sen_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;

   // The first bit leaves on the transfer edge; shreg_q keeps only the bits still to send.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         mode_q   <= 1'b0;
         cnt_q    <= '0;
         sdata_q  <= 1'b0;
         sen_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef PARITY_EN
         parity_q <= 1'b0;
`endif
      end else if (xfer_c) begin
         state_q  <= SHIFT;
         mode_q   <= load_mode_i;
         cnt_q    <= '0;
         sen_q    <= 1'b1;
         busy_q   <= 1'b1;
         done_q   <= 1'b0;
`ifdef PARITY_EN
         parity_q <= ^load_data_i;
`endif
         if (load_mode_i) begin
            sdata_q <= load_data_i[0];
            shreg_q <= {1'b0, load_data_i[N-1:1]};
         end else begin
            sdata_q <= load_data_i[N-1];
            shreg_q <= {load_data_i[N-2:0], 1'b0};
         end
      end else if (state_q == SHIFT) begin
         if (last_c) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            sdata_q <= 1'b0;
            sen_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
         end else begin
            cnt_q  <= cnt_inc_c;
            done_q <= (cnt_inc_c == LAST_C);
`ifdef PARITY_EN
            if (cnt_q == CW'(N - 1)) begin
               sdata_q <= parity_q;
            end else
`endif
            if (mode_q) begin
               sdata_q <= shreg_q[0];
               shreg_q <= {1'b0, shreg_q[N-1:1]};
            end else begin
               sdata_q <= shreg_q[N-1];
               shreg_q <= {shreg_q[N-2:0], 1'b0};
            end
         end
      end
   end

endmodule

// File: tb/tb_bidir_serial_tx.sv
// Scoreboard bench for bidir_serial_tx (N=4): driver pushes expected bits, monitor pops on sen.
// Compile with PARITY_EN defined to exercise the parity trailer.
module tb_bidir_serial_tx;
   localparam int N = 4;
`ifdef PARITY_EN
   localparam int FRAME = N + 1;
`else
   localparam int FRAME = N;
`endif

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         load_valid_i;
   logic         load_ready_o;
   logic [N-1:0] load_data_i;
   logic         load_mode_i;
   logic         sdata_o;
   logic         sen_o;
   logic         busy_o;
   logic         done_o;

   bidir_serial_tx #(.N(N)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .load_valid_i (load_valid_i),
      .load_ready_o (load_ready_o),
      .load_data_i  (load_data_i),
      .load_mode_i  (load_mode_i),
      .sdata_o      (sdata_o),
      .sen_o        (sen_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic         b;
      logic         d;
      logic         is_data;
      logic         mode;
      logic [N-1:0] word;
   } exp_t;

   exp_t         exp_q[$];
   int           checks   = 0;
   int           failures = 0;
   int           done_cnt = 0;
   bit           started  = 1'b0;
   logic [N-1:0] rx       = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // seq lists the expected serial bits, first-sent bit in seq[N-1]
   task automatic send(input logic [N-1:0] word, input logic mode,
                       input logic [N-1:0] seq, input logic par);
      int n;
      exp_t e;
      load_valid_i = 1'b1;
      load_data_i  = word;
      load_mode_i  = mode;
      n = 0;
      while (!load_ready_o && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      chk("send_ready", {31'd0, load_ready_o}, 32'd1);
      @(posedge clk_i);
      for (int i = 0; i < N; i++) begin
         e.b       = seq[N-1-i];
         e.d       = (i == N - 1) && (FRAME == N);
         e.is_data = 1'b1;
         e.mode    = mode;
         e.word    = word;
         exp_q.push_back(e);
      end
      if (FRAME > N) begin
         e.b       = par;
         e.d       = 1'b1;
         e.is_data = 1'b0;
         e.mode    = mode;
         e.word    = word;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      chk("drain", exp_q.size(), 32'd0);
      @(negedge clk_i);
   endtask

   initial begin : monitor
      exp_t e;
      wait (started);
      forever begin
         @(posedge clk_i);
         #1;
         if (sen_o === 1'b1) begin
            chk("sen_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            chk("busy_in_frame", {31'd0, busy_o}, 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("sdata", {31'd0, sdata_o}, {31'd0, e.b});
               chk("done", {31'd0, done_o}, {31'd0, e.d});
               if (e.is_data)
                  rx = e.mode ? {sdata_o, rx[N-1:1]} : {rx[N-2:0], sdata_o};
               if (e.d) begin
                  done_cnt++;
                  chk("rx_word", {28'd0, rx}, {28'd0, e.word});
               end
            end
         end else begin
            chk("idle_done", {31'd0, done_o}, 32'd0);
            chk("idle_busy", {31'd0, busy_o}, 32'd0);
            chk("no_gap", exp_q.size(), 32'd0);
         end
      end
   end

   initial begin : driver
      int d0;
      rst_i        = 1'b0;
      load_valid_i = 1'b0;
      load_data_i  = '0;
      load_mode_i  = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_i   = 1'b1;
      started = 1'b1;

      // reset held two cycles in the middle of a frame
      @(negedge clk_i);
      send(4'hC, 1'b1, 4'b0011, 1'b0);
      @(negedge clk_i);
      load_valid_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      exp_q.delete();
      @(negedge clk_i);
      @(negedge clk_i);
      chk("rst_sdata", {31'd0, sdata_o}, 32'd0);
      chk("rst_sen", {31'd0, sen_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      chk("rst_ready", {31'd0, load_ready_o}, 32'd1);
      rst_i = 1'b1;

      // LSB first with ready pattern across the frame
      @(negedge clk_i);
      send(4'b1011, 1'b1, 4'b1101, 1'b1);
      for (int k = 1; k <= FRAME; k++) begin
         @(negedge clk_i);
         if (k == 1) load_valid_i = 1'b0;
         chk("ready_in_frame", {31'd0, load_ready_o}, {31'd0, k == FRAME});
         chk("busy_level", {31'd0, busy_o}, 32'd1);
      end
      wait_drain();

      // MSB first
      send(4'b1011, 1'b0, 4'b1011, 1'b1);
      @(negedge clk_i);
      load_valid_i = 1'b0;
      wait_drain();

      // back-to-back with valid held high
      d0 = done_cnt;
      send(4'hA, 1'b1, 4'b0101, 1'b0);
      @(negedge clk_i);
      send(4'h5, 1'b1, 4'b1010, 1'b0);
      @(negedge clk_i);
      load_valid_i = 1'b0;
      wait_drain();
      chk("b2b_done_pulses", done_cnt - d0, 32'd2);

      // abort after two bits, then a clean frame
      send(4'hF, 1'b1, 4'b1111, 1'b0);
      @(negedge clk_i);
      load_valid_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      exp_q.delete();
      @(negedge clk_i);
      chk("abort_sen", {31'd0, sen_o}, 32'd0);
      chk("abort_busy", {31'd0, busy_o}, 32'd0);
      chk("abort_ready", {31'd0, load_ready_o}, 32'd1);
      rst_i = 1'b1;
      @(negedge clk_i);
      send(4'h3, 1'b1, 4'b1100, 1'b0);
      @(negedge clk_i);
      load_valid_i = 1'b0;
      wait_drain();

      // MSB-first back-to-back: second word's first bit is its MSB
      send(4'h9, 1'b0, 4'b1001, 1'b0);
      @(negedge clk_i);
      send(4'h6, 1'b0, 4'b0110, 1'b0);
      @(negedge clk_i);
      load_valid_i = 1'b0;
      wait_drain();

      repeat (3) @(negedge clk_i);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
